// File: rtl/updi_session_sequencer.sv
// UPDI session sequencer: double-break/STATUSA link bring-up, then optional chip-erase
// and/or NVMPROG key unlock with reset toggle and ASI_SYS_STATUS polling.
module updi_session_sequencer #(
    parameter int unsigned MAX_LINK_RETRIES   = 3,
    parameter int unsigned TXN_TIMEOUT_CLKS   = 4096,
    parameter int unsigned POLL_INTERVAL_CLKS = 100,
    parameter int unsigned POLL_MAX           = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] error_code,
    output logic       double_break_start,
    input  logic       double_break_done,
    input  logic       txn_ready,
    output logic       txn_start,
    output logic [1:0] txn_op,
    output logic [3:0] txn_cs_addr,
    output logic [7:0] txn_wdata,
    output logic       txn_key_sel,
    input  logic       txn_done,
    input  logic [7:0] txn_rx_data,
    input  logic       txn_ack_error
);
    localparam int unsigned RETRY_W = ($clog2(MAX_LINK_RETRIES + 1) > 0) ? $clog2(MAX_LINK_RETRIES + 1) : 1;
    localparam int unsigned TMR_W   = $clog2(TXN_TIMEOUT_CLKS + 1);
    localparam int unsigned WAIT_W  = $clog2(POLL_INTERVAL_CLKS + 1);
    localparam int unsigned POLL_W  = $clog2(POLL_MAX + 1);

    localparam logic [1:0] OP_LDCS = 2'd0;
    localparam logic [1:0] OP_STCS = 2'd1;
    localparam logic [1:0] OP_KEY  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_DB_START, S_DB_WAIT, S_RD_LINK, S_CHK_LINK, S_SEND_KEY, S_RD_KEYSTAT,
        S_CHK_KEY, S_RST_SET, S_RST_CLR, S_POLL_WAIT, S_POLL_RD, S_CHK_POLL, S_FINISH, S_FAIL
    } state_t;

    state_t             state_q, state_d, txn_next;
    logic [1:0]         mode_q, mode_d;
    logic               phase_q, phase_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic               pend_q, pend_d;
    logic [7:0]         rx_q, rx_d;
    logic               is_txn;
    logic [1:0]         req_op;
    logic [3:0]         req_addr;
    logic [7:0]         req_wdata;
    logic [2:0]         fail_code;
    logic               error_d, txn_op_unused;
    logic [2:0]         error_code_d;
    logic [1:0]         txn_op_d;
    logic [3:0]         txn_cs_addr_d;
    logic [7:0]         txn_wdata_d;
    logic               txn_key_sel_d, txn_start_d;

    assign txn_op_unused = 1'b0;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            mode_q             <= 2'd0;
            phase_q            <= 1'b0;
            retry_q            <= '0;
            tmr_q              <= '0;
            wait_q             <= '0;
            poll_q             <= '0;
            pend_q             <= 1'b0;
            rx_q               <= 8'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            error_code         <= 3'd0;
            double_break_start <= 1'b0;
            txn_start          <= 1'b0;
            txn_op             <= 2'd0;
            txn_cs_addr        <= 4'd0;
            txn_wdata          <= 8'd0;
            txn_key_sel        <= 1'b0;
        end else begin
            state_q            <= state_d;
            mode_q             <= mode_d;
            phase_q            <= phase_d;
            retry_q            <= retry_d;
            tmr_q              <= tmr_d;
            wait_q             <= wait_d;
            poll_q             <= poll_d;
            pend_q             <= pend_d;
            rx_q               <= rx_d;
            busy               <= (state_d != S_IDLE);
            done               <= (state_d == S_FINISH) || (state_d == S_FAIL);
            error              <= error_d;
            error_code         <= error_code_d;
            double_break_start <= (state_d == S_DB_START);
            txn_start          <= txn_start_d;
            txn_op             <= txn_op_d;
            txn_cs_addr        <= txn_cs_addr_d;
            txn_wdata          <= txn_wdata_d;
            txn_key_sel        <= txn_key_sel_d;
        end
    end

    // Next-state, counters and transaction issue
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        phase_d       = phase_q;
        retry_d       = retry_q;
        tmr_d         = tmr_q;
        wait_d        = wait_q;
        poll_d        = poll_q;
        pend_d        = pend_q;
        rx_d          = rx_q;
        error_d       = error;
        error_code_d  = error_code;
        txn_start_d   = 1'b0;
        txn_op_d      = txn_op;
        txn_cs_addr_d = txn_cs_addr;
        txn_wdata_d   = txn_wdata;
        txn_key_sel_d = txn_key_sel;
        is_txn        = 1'b0;
        req_op        = OP_LDCS;
        req_addr      = 4'h0;
        req_wdata     = 8'h00;
        txn_next      = S_IDLE;
        fail_code     = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    phase_d      = (mode == 2'b10);
                    retry_d      = '0;
                    poll_d       = '0;
                    wait_d       = '0;
                    error_d      = 1'b0;
                    error_code_d = 3'd0;
                    state_d      = S_DB_START;
                end
            end
            S_DB_START: state_d = S_DB_WAIT;
            S_DB_WAIT:  if (double_break_done) state_d = S_RD_LINK;
            S_RD_LINK: begin
                is_txn = 1'b1; req_addr = 4'h0; txn_next = S_CHK_LINK;
            end
            S_CHK_LINK: begin
                if (rx_q != 8'd0) begin
                    if (mode_q == 2'b00) begin
                        state_d = S_FINISH;
                    end else begin
                        phase_d = (mode_q == 2'b10);
                        poll_d  = '0;
                        state_d = S_SEND_KEY;
                    end
                end else if (retry_q < RETRY_W'(MAX_LINK_RETRIES)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_DB_START;
                end else begin
                    fail_code = 3'd1; state_d = S_FAIL;
                end
            end
            S_SEND_KEY: begin
                is_txn = 1'b1; req_op = OP_KEY; txn_next = S_RD_KEYSTAT;
            end
            S_RD_KEYSTAT: begin
                is_txn = 1'b1; req_addr = 4'h7; txn_next = S_CHK_KEY;
            end
            S_CHK_KEY: begin
                if (phase_q ? rx_q[4] : rx_q[3]) state_d = S_RST_SET;
                else begin
                    fail_code = 3'd4; state_d = S_FAIL;
                end
            end
            S_RST_SET: begin
                is_txn = 1'b1; req_op = OP_STCS; req_addr = 4'h8; req_wdata = 8'h59;
                txn_next = S_RST_CLR;
            end
            S_RST_CLR: begin
                is_txn = 1'b1; req_op = OP_STCS; req_addr = 4'h8; txn_next = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (wait_q >= WAIT_W'(POLL_INTERVAL_CLKS - 1)) begin
                    wait_d  = '0;
                    state_d = S_POLL_RD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_POLL_RD: begin
                is_txn = 1'b1; req_addr = 4'hB; txn_next = S_CHK_POLL;
            end
            S_CHK_POLL: begin
                if (phase_q ? rx_q[3] : !rx_q[0]) begin
                    if (!phase_q && (mode_q == 2'b11)) begin
                        phase_d = 1'b1;
                        poll_d  = '0;
                        state_d = S_SEND_KEY;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (poll_q < POLL_W'(POLL_MAX - 1)) begin
                    poll_d  = poll_q + POLL_W'(1);
                    state_d = S_POLL_WAIT;
                end else begin
                    poll_d    = POLL_W'(POLL_MAX);
                    fail_code = 3'd5;
                    state_d   = S_FAIL;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // One outstanding transaction; a missing txn_done fails before any result is used
        if (is_txn) begin
            if (!pend_q) begin
                if (txn_ready) begin
                    txn_start_d   = 1'b1;
                    pend_d        = 1'b1;
                    tmr_d         = '0;
                    txn_op_d      = req_op;
                    txn_cs_addr_d = req_addr;
                    txn_wdata_d   = req_wdata;
                    txn_key_sel_d = phase_q;
                end
            end else if (txn_done) begin
                pend_d = 1'b0;
                rx_d   = txn_rx_data;
                if (txn_ack_error) begin
                    fail_code = 3'd3; state_d = S_FAIL;
                end else begin
                    state_d = txn_next;
                end
            end else if (tmr_q >= TMR_W'(TXN_TIMEOUT_CLKS - 1)) begin
                pend_d    = 1'b0;
                fail_code = 3'd2;
                state_d   = S_FAIL;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        if (state_d == S_FAIL && state_q != S_FAIL) begin
            error_d      = 1'b1;
            error_code_d = fail_code;
        end
    end
endmodule
